// File: rtl/io_bus_ctrl_pkg.sv
// Shared state codes, I/O address map and decode helpers for the
// memory-mapped I/O bus controller.
package io_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RCAP   = 2'd2,
        ST_RESP   = 2'd3
    } io_state_e;

    localparam logic [11:0] IO_DIG       = 12'h000;
    localparam logic [11:0] IO_TIMER     = 12'h020;
    localparam logic [11:0] IO_TIMER_SET = 12'h024;
    localparam logic [11:0] IO_LED       = 12'h060;
    localparam logic [11:0] IO_SW        = 12'h070;
    localparam logic [11:0] IO_BTN       = 12'h078;

    typedef enum logic [2:0] {
        TGT_NONE      = 3'd0,
        TGT_DIG       = 3'd1,
        TGT_TIMER     = 3'd2,
        TGT_TIMER_SET = 3'd3,
        TGT_LED       = 3'd4,
        TGT_SW        = 3'd5,
        TGT_BTN       = 3'd6
    } io_tgt_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } io_req_t;

    // Word offset inside the window; byte-lane bits are not part of the decode.
    function automatic io_tgt_e io_decode(input logic in_window, input logic [11:2] word_off);
        io_tgt_e tgt;
        tgt = TGT_NONE;
        if (in_window) begin
            if (word_off == IO_DIG[11:2])            tgt = TGT_DIG;
            else if (word_off == IO_TIMER[11:2])     tgt = TGT_TIMER;
            else if (word_off == IO_TIMER_SET[11:2]) tgt = TGT_TIMER_SET;
            else if (word_off == IO_LED[11:2])       tgt = TGT_LED;
            else if (word_off == IO_SW[11:2])        tgt = TGT_SW;
            else if (word_off == IO_BTN[11:2])       tgt = TGT_BTN;
            else                                     tgt = TGT_NONE;
        end
        return tgt;
    endfunction

    function automatic logic io_is_write_tgt(input io_tgt_e tgt);
        return (tgt == TGT_DIG) || (tgt == TGT_TIMER_SET) || (tgt == TGT_LED);
    endfunction

    function automatic logic io_is_read_tgt(input io_tgt_e tgt);
        return (tgt == TGT_TIMER) || (tgt == TGT_SW) || (tgt == TGT_BTN);
    endfunction

endpackage

// File: rtl/io_bus_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module io_rr_arbiter
    import io_bus_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] win
);

    logic last_q;
    logic last_d;

    // last_q = 1 means m1 was granted most recently; reset favours m0.
    always_comb begin
        win = 2'b00;
        unique case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_q ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase

        last_d = last_q;
        if (advance && (req != 2'b00)) begin
            last_d = win[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O bus controller: arbitrates m0/m1, decodes the I/O window
// and sequences fixed-length write and read transactions.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a request; arbitrate and latch the winner
//   ST_ACCESS | gnt (and write strobe) visible, io_addr/io_wdata driven
//   ST_RCAP   | read source sampled into the owner's read-data register
//   ST_RESP   | rvalid/rdata visible to the owner
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'hFFFF_F000
) (
    input  logic        io_clk,
    input  logic        io_rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] io_addr,
    output logic        dig_we,
    output logic        led_we,
    output logic        timer_set_we,
    output logic [31:0] io_wdata,
    input  logic [31:0] sw_rdata,
    input  logic [31:0] btn_rdata,
    input  logic [31:0] timer_rdata
);

    io_state_e   state_q, state_d;
    logic        owner_q, owner_d;
    io_req_t     lat_q, lat_d;
    io_tgt_e     tgt_q, tgt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [1:0]  err_q, err_d;
    logic        dig_we_q, dig_we_d;
    logic        led_we_q, led_we_d;
    logic        tset_we_q, tset_we_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic [1:0]  req;
    logic [1:0]  win;
    logic        accept;
    io_req_t     sel_req;
    io_tgt_e     sel_tgt;
    logic        rd_legal;
    logic [31:0] rd_src;

    assign req    = {m1_req, m0_req};
    assign accept = (state_q == ST_IDLE) && (req != 2'b00);

    io_rr_arbiter u_arb (
        .clk     (io_clk),
        .rst     (io_rst),
        .req     (req),
        .advance (accept),
        .win     (win)
    );

    always_comb begin
        if (win[1]) begin
            sel_req.we    = m1_we;
            sel_req.addr  = m1_addr;
            sel_req.wdata = m1_wdata;
        end else begin
            sel_req.we    = m0_we;
            sel_req.addr  = m0_addr;
            sel_req.wdata = m0_wdata;
        end
        // The base is 4 KiB aligned, so the window test is an upper-bit compare.
        sel_tgt = io_decode(sel_req.addr[31:12] == IO_BASE[31:12], sel_req.addr[11:2]);
    end

    always_comb begin
        rd_legal = io_is_read_tgt(tgt_q);
        unique case (tgt_q)
            TGT_TIMER: rd_src = timer_rdata;
            TGT_SW:    rd_src = sw_rdata;
            TGT_BTN:   rd_src = btn_rdata;
            default:   rd_src = 32'h0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        tgt_d     = tgt_q;
        gnt_d     = 2'b00;
        rvalid_d  = 2'b00;
        err_d     = 2'b00;
        dig_we_d  = 1'b0;
        led_we_d  = 1'b0;
        tset_we_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = win[1];
                    lat_d   = sel_req;
                    tgt_d   = sel_tgt;
                    gnt_d   = win;
                    state_d = ST_ACCESS;
                    if (sel_req.we) begin
                        dig_we_d  = (sel_tgt == TGT_DIG);
                        led_we_d  = (sel_tgt == TGT_LED);
                        tset_we_d = (sel_tgt == TGT_TIMER_SET);
                        if (!io_is_write_tgt(sel_tgt)) begin
                            err_d = win;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                state_d = lat_q.we ? ST_IDLE : ST_RCAP;
            end
            ST_RCAP: begin
                state_d = ST_RESP;
                if (owner_q) begin
                    rdata1_d = rd_src;
                    rvalid_d = 2'b10;
                    err_d    = {~rd_legal, 1'b0};
                end else begin
                    rdata0_d = rd_src;
                    rvalid_d = 2'b01;
                    err_d    = {1'b0, ~rd_legal};
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            lat_q     <= '0;
            tgt_q     <= TGT_NONE;
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
            err_q     <= 2'b00;
            dig_we_q  <= 1'b0;
            led_we_q  <= 1'b0;
            tset_we_q <= 1'b0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_q     <= lat_d;
            tgt_q     <= tgt_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            dig_we_q  <= dig_we_d;
            led_we_q  <= led_we_d;
            tset_we_q <= tset_we_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign m0_gnt       = gnt_q[0];
    assign m1_gnt       = gnt_q[1];
    assign m0_rvalid    = rvalid_q[0];
    assign m1_rvalid    = rvalid_q[1];
    assign m0_err       = err_q[0];
    assign m1_err       = err_q[1];
    assign m0_rdata     = rdata0_q;
    assign m1_rdata     = rdata1_q;
    assign io_addr      = lat_q.addr;
    assign io_wdata     = lat_q.wdata;
    assign dig_we       = dig_we_q;
    assign led_we       = led_we_q;
    assign timer_set_we = tset_we_q;

endmodule
